// File: rtl/mure_pkg.sv
// Shared widths and the FIFO entry record used between the commit ingress
// buffer and the trace-connector instruction FSM.
package mure_pkg;

  localparam int unsigned XLEN      = 64;
  localparam int unsigned ITYPE_LEN = 3;
  localparam int unsigned CAUSE_LEN = 5;
  localparam int unsigned PRIV_LEN  = 2;

  typedef struct packed {
    logic                 valid;
    logic [ITYPE_LEN-1:0] itype;
    logic [CAUSE_LEN-1:0] cause;
    logic [XLEN-1:0]      tval;
    logic [PRIV_LEN-1:0]  priv;
    logic [XLEN-1:0]      pc;
    logic                 compressed;
  } fifo_entry_s;

endpackage

// File: rtl/commit_fifo_if.sv
// Bundle of commit-side inputs and head/status outputs of commit_fifo.
// master = commit producer / consumer side, slave = the FIFO itself.
interface commit_fifo_if #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = $clog2(DEPTH)
);
  import mure_pkg::*;

  logic                           flush_i;
  logic [1:0]                     valid_i;
  logic [1:0][XLEN-1:0]           pc_i;
  logic [1:0]                     compressed_i;
  logic [1:0][ITYPE_LEN-1:0]      itype_i;
  logic                           exc_valid_i;
  logic [CAUSE_LEN-1:0]           cause_i;
  logic [XLEN-1:0]                tval_i;
  logic [PRIV_LEN-1:0]            priv_i;
  fifo_entry_s                    fifo_entry_o;
  logic [PTR_W:0]                 count_o;
  logic                           overflow_o;

  modport master (
    output flush_i, valid_i, pc_i, compressed_i, itype_i,
           exc_valid_i, cause_i, tval_i, priv_i,
    input  fifo_entry_o, count_o, overflow_o
  );

  modport slave (
    input  flush_i, valid_i, pc_i, compressed_i, itype_i,
           exc_valid_i, cause_i, tval_i, priv_i,
    output fifo_entry_o, count_o, overflow_o
  );

endinterface

// File: rtl/commit_fifo.sv
// Ingress buffer serialising up to two retired instructions per cycle (plus an
// optional exception) into program order; one entry is consumed every cycle.
module commit_fifo
  import mure_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  commit_fifo_if.slave  bus_io
);

  localparam int unsigned CNT_W = PTR_W + 1;

  fifo_entry_s             mem_q [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, wr_ptr_inc;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    overflow_q, overflow_d;

  fifo_entry_s [1:0]       req;
  fifo_entry_s             rec0, rec1;
  logic [1:0]              n_req, n_push;
  logic [CNT_W-1:0]        free_slots;
  logic                    pop;
  logic                    drop;

  // Build the ordered push request list; an exception collapses it to port 0.
  always_comb begin
    rec0            = '0;
    rec0.valid      = 1'b1;
    rec0.pc         = bus_io.pc_i[0];
    rec0.compressed = bus_io.compressed_i[0];
    rec0.itype      = bus_io.itype_i[0];
    rec0.priv       = bus_io.priv_i;

    rec1            = '0;
    rec1.valid      = 1'b1;
    rec1.pc         = bus_io.pc_i[1];
    rec1.compressed = bus_io.compressed_i[1];
    rec1.itype      = bus_io.itype_i[1];
    rec1.priv       = bus_io.priv_i;

    req   = '0;
    n_req = '0;
    if (bus_io.exc_valid_i) begin
      req[0]       = rec0;
      req[0].itype = ITYPE_LEN'(1);
      req[0].cause = bus_io.cause_i;
      req[0].tval  = bus_io.tval_i;
      n_req        = 2'd1;
    end else begin
      unique case (bus_io.valid_i)
        2'b01: begin
          req[0] = rec0;
          n_req  = 2'd1;
        end
        2'b10: begin
          req[0] = rec1;
          n_req  = 2'd1;
        end
        2'b11: begin
          req[0] = rec0;
          req[1] = rec1;
          n_req  = 2'd2;
        end
        default: begin
          n_req = 2'd0;
        end
      endcase
    end
  end

  // A same-cycle pop frees a slot, so free never exceeds DEPTH.
  always_comb begin
    pop        = (count_q != '0);
    free_slots = CNT_W'(DEPTH) - count_q + CNT_W'(pop);
    drop       = 1'b0;
    if (CNT_W'(n_req) <= free_slots) begin
      n_push = n_req;
    end else begin
      n_push = free_slots[1:0];
      drop   = 1'b1;
    end
  end

  assign wr_ptr_inc = wr_ptr_q + PTR_W'(1);

  always_comb begin
    wr_ptr_d   = wr_ptr_q + PTR_W'(n_push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    count_d    = count_q + CNT_W'(n_push) - CNT_W'(pop);
    overflow_d = overflow_q | drop;
    if (bus_io.flush_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is left unreset; the empty gating on the output hides stale data.
  always_ff @(posedge clk_i) begin
    if (!bus_io.flush_i) begin
      if (n_push != 2'd0) begin
        mem_q[wr_ptr_q] <= req[0];
      end
      if (n_push == 2'd2) begin
        mem_q[wr_ptr_inc] <= req[1];
      end
    end
  end

  assign bus_io.fifo_entry_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign bus_io.count_o      = count_q;
  assign bus_io.overflow_o   = overflow_q;

endmodule

// File: tb/tb_commit_fifo.sv
// Directed bench for commit_fifo: ordering, exceptions, overflow/wrap, flush, reset.
module tb_commit_fifo;
  import mure_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic clk    = 1'b0;
  logic rst_ni = 1'b0;
  int   tests  = 0;
  int   fails  = 0;

  commit_fifo_if #(.DEPTH(DEPTH)) bus ();

  commit_fifo #(.DEPTH(DEPTH)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush_i      = 1'b0;
    bus.valid_i      = 2'b00;
    bus.pc_i         = '0;
    bus.compressed_i = 2'b00;
    bus.itype_i      = '0;
    bus.exc_valid_i  = 1'b0;
    bus.cause_i      = '0;
    bus.tval_i       = '0;
    bus.priv_i       = 2'd3;
  endtask

  function automatic fifo_entry_s mk(logic [63:0] pc, logic c, logic [2:0] it,
                                     logic [4:0] cause, logic [63:0] tval, logic [1:0] priv);
    fifo_entry_s e;
    e            = '0;
    e.valid      = 1'b1;
    e.pc         = pc;
    e.compressed = c;
    e.itype      = it;
    e.cause      = cause;
    e.tval       = tval;
    e.priv       = priv;
    return e;
  endfunction

  task automatic test_reset();
    idle();
    #12;
    tests++; if (bus.count_o !== 4'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", bus.count_o); end
    tests++; if (bus.overflow_o !== 1'b0) begin fails++; $display("FAIL reset_overflow got %b exp 0", bus.overflow_o); end
    tests++; if (bus.fifo_entry_o !== '0) begin fails++; $display("FAIL reset_entry got %h exp 0", bus.fifo_entry_o); end
    @(negedge clk);
    rst_ni = 1'b1;
    tick();
    tests++; if (bus.count_o !== 4'd0) begin fails++; $display("FAIL post_reset_count got %0d exp 0", bus.count_o); end
  endtask

  task automatic test_single();
    fifo_entry_s exp;
    bus.valid_i   = 2'b01;
    bus.pc_i[0]   = 64'h8000_0000;
    bus.priv_i    = 2'd3;
    tick();
    idle();
    exp = mk(64'h8000_0000, 1'b0, 3'd0, 5'd0, 64'd0, 2'd3);
    tests++; if (bus.fifo_entry_o !== exp) begin fails++; $display("FAIL single_entry got %h exp %h", bus.fifo_entry_o, exp); end
    tests++; if (bus.count_o !== 4'd1) begin fails++; $display("FAIL single_count got %0d exp 1", bus.count_o); end
    tick();
    tests++; if (bus.fifo_entry_o !== '0) begin fails++; $display("FAIL single_empty got %h exp 0", bus.fifo_entry_o); end
    tests++; if (bus.count_o !== 4'd0) begin fails++; $display("FAIL single_count_end got %0d exp 0", bus.count_o); end
  endtask

  task automatic test_dual();
    fifo_entry_s exp;
    tests++; if (bus.count_o !== 4'd0) begin fails++; $display("FAIL dual_count0 got %0d exp 0", bus.count_o); end
    bus.valid_i         = 2'b11;
    bus.pc_i[0]         = 64'h100;
    bus.compressed_i[0] = 1'b1;
    bus.pc_i[1]         = 64'h102;
    bus.itype_i[1]      = 3'd4;
    tick();
    idle();
    exp = mk(64'h100, 1'b1, 3'd0, 5'd0, 64'd0, 2'd3);
    tests++; if (bus.count_o !== 4'd2) begin fails++; $display("FAIL dual_count2 got %0d exp 2", bus.count_o); end
    tests++; if (bus.fifo_entry_o !== exp) begin fails++; $display("FAIL dual_first got %h exp %h", bus.fifo_entry_o, exp); end
    tick();
    exp = mk(64'h102, 1'b0, 3'd4, 5'd0, 64'd0, 2'd3);
    tests++; if (bus.count_o !== 4'd1) begin fails++; $display("FAIL dual_count1 got %0d exp 1", bus.count_o); end
    tests++; if (bus.fifo_entry_o !== exp) begin fails++; $display("FAIL dual_second got %h exp %h", bus.fifo_entry_o, exp); end
    tick();
    tests++; if (bus.count_o !== 4'd0) begin fails++; $display("FAIL dual_count_end got %0d exp 0", bus.count_o); end
    tests++; if (bus.fifo_entry_o !== '0) begin fails++; $display("FAIL dual_empty got %h exp 0", bus.fifo_entry_o); end
  endtask

  task automatic test_exception();
    fifo_entry_s exp;
    bus.valid_i     = 2'b11;
    bus.exc_valid_i = 1'b1;
    bus.cause_i     = 5'd2;
    bus.tval_i      = 64'hDEAD;
    bus.pc_i[0]     = 64'h200;
    bus.pc_i[1]     = 64'h204;
    bus.itype_i[1]  = 3'd4;
    bus.priv_i      = 2'd1;
    tick();
    idle();
    exp = mk(64'h200, 1'b0, 3'd1, 5'd2, 64'hDEAD, 2'd1);
    tests++; if (bus.count_o !== 4'd1) begin fails++; $display("FAIL exc_count got %0d exp 1", bus.count_o); end
    tests++; if (bus.fifo_entry_o !== exp) begin fails++; $display("FAIL exc_entry got %h exp %h", bus.fifo_entry_o, exp); end
    tick();
    tests++; if (bus.count_o !== 4'd0) begin fails++; $display("FAIL exc_port1_absent got %0d exp 0", bus.count_o); end
    bus.valid_i         = 2'b00;
    bus.exc_valid_i     = 1'b1;
    bus.cause_i         = 5'd5;
    bus.tval_i          = 64'h44;
    bus.pc_i[0]         = 64'h300;
    bus.compressed_i[0] = 1'b1;
    bus.itype_i[0]      = 3'd3;
    bus.priv_i          = 2'd0;
    tick();
    idle();
    exp = mk(64'h300, 1'b1, 3'd1, 5'd5, 64'h44, 2'd0);
    tests++; if (bus.count_o !== 4'd1) begin fails++; $display("FAIL exc_novalid_count got %0d exp 1", bus.count_o); end
    tests++; if (bus.fifo_entry_o !== exp) begin fails++; $display("FAIL exc_novalid_entry got %h exp %h", bus.fifo_entry_o, exp); end
    tick();
    tests++; if (bus.fifo_entry_o !== '0) begin fails++; $display("FAIL exc_empty got %h exp 0", bus.fifo_entry_o); end
  endtask

  task automatic test_overflow_wrap();
    logic [63:0] q[$];
    fifo_entry_s exp;
    int unsigned exp_cnt;
    for (int k = 0; k < 8; k++) begin
      bus.valid_i = 2'b11;
      bus.pc_i[0] = 64'h1000 + 64'(16 * k);
      bus.pc_i[1] = 64'h1008 + 64'(16 * k);
      q.push_back(bus.pc_i[0]);
      if (k < 7) q.push_back(bus.pc_i[1]);
      tick();
      exp     = mk(q[k], 1'b0, 3'd0, 5'd0, 64'd0, 2'd3);
      exp_cnt = (k + 2 > 8) ? 8 : k + 2;
      tests++; if (bus.fifo_entry_o !== exp) begin fails++; $display("FAIL ovf_fill_head[%0d] got %h exp %h", k, bus.fifo_entry_o, exp); end
      tests++; if (bus.count_o !== 4'(exp_cnt)) begin fails++; $display("FAIL ovf_fill_count[%0d] got %0d exp %0d", k, bus.count_o, exp_cnt); end
      tests++; if (bus.overflow_o !== (k == 7)) begin fails++; $display("FAIL ovf_flag[%0d] got %b exp %b", k, bus.overflow_o, k == 7); end
    end
    idle();
    for (int j = 8; j < 15; j++) begin
      tick();
      exp = mk(q[j], 1'b0, 3'd0, 5'd0, 64'd0, 2'd3);
      tests++; if (bus.fifo_entry_o !== exp) begin fails++; $display("FAIL ovf_drain_head[%0d] got %h exp %h", j, bus.fifo_entry_o, exp); end
      tests++; if (bus.count_o !== 4'(15 - j)) begin fails++; $display("FAIL ovf_drain_count[%0d] got %0d exp %0d", j, bus.count_o, 15 - j); end
      tests++; if (bus.overflow_o !== 1'b1) begin fails++; $display("FAIL ovf_sticky[%0d] got %b exp 1", j, bus.overflow_o); end
    end
    tick();
    tests++; if (bus.fifo_entry_o !== '0) begin fails++; $display("FAIL ovf_empty got %h exp 0", bus.fifo_entry_o); end
    tests++; if (bus.overflow_o !== 1'b1) begin fails++; $display("FAIL ovf_sticky_empty got %b exp 1", bus.overflow_o); end
  endtask

  task automatic test_flush();
    fifo_entry_s exp;
    tests++; if (bus.overflow_o !== 1'b1) begin fails++; $display("FAIL flush_pre_overflow got %b exp 1", bus.overflow_o); end
    for (int k = 0; k < 4; k++) begin
      bus.valid_i = 2'b11;
      bus.pc_i[0] = 64'h4000 + 64'(16 * k);
      bus.pc_i[1] = 64'h4008 + 64'(16 * k);
      tick();
    end
    tests++; if (bus.count_o !== 4'd5) begin fails++; $display("FAIL flush_fill_count got %0d exp 5", bus.count_o); end
    bus.flush_i = 1'b1;
    bus.pc_i[0] = 64'h5000;
    bus.pc_i[1] = 64'h5008;
    #1;
    exp = mk(64'h4018, 1'b0, 3'd0, 5'd0, 64'd0, 2'd3);
    tests++; if (bus.fifo_entry_o !== exp) begin fails++; $display("FAIL flush_cycle_head got %h exp %h", bus.fifo_entry_o, exp); end
    tick();
    idle();
    tests++; if (bus.count_o !== 4'd0) begin fails++; $display("FAIL flush_count got %0d exp 0", bus.count_o); end
    tests++; if (bus.fifo_entry_o !== '0) begin fails++; $display("FAIL flush_entry got %h exp 0", bus.fifo_entry_o); end
    tests++; if (bus.overflow_o !== 1'b0) begin fails++; $display("FAIL flush_overflow got %b exp 0", bus.overflow_o); end
    tick();
    tests++; if (bus.count_o !== 4'd0) begin fails++; $display("FAIL flush_push_discarded got %0d exp 0", bus.count_o); end
  endtask

  task automatic test_full_pop();
    logic [63:0] q[$];
    fifo_entry_s exp;
    for (int k = 0; k < 7; k++) begin
      bus.valid_i = 2'b11;
      bus.pc_i[0] = 64'h6000 + 64'(16 * k);
      bus.pc_i[1] = 64'h6008 + 64'(16 * k);
      q.push_back(bus.pc_i[0]);
      q.push_back(bus.pc_i[1]);
      tick();
    end
    tests++; if (bus.count_o !== 4'd8) begin fails++; $display("FAIL full_count got %0d exp 8", bus.count_o); end
    bus.valid_i = 2'b01;
    bus.pc_i[0] = 64'h7000;
    q.push_back(64'h7000);
    tick();
    exp = mk(q[7], 1'b0, 3'd0, 5'd0, 64'd0, 2'd3);
    tests++; if (bus.count_o !== 4'd8) begin fails++; $display("FAIL full_pop_count got %0d exp 8", bus.count_o); end
    tests++; if (bus.overflow_o !== 1'b0) begin fails++; $display("FAIL full_pop_overflow got %b exp 0", bus.overflow_o); end
    tests++; if (bus.fifo_entry_o !== exp) begin fails++; $display("FAIL full_pop_head got %h exp %h", bus.fifo_entry_o, exp); end
    bus.valid_i = 2'b10;
    bus.pc_i[0] = 64'h7200;
    bus.pc_i[1] = 64'h7100;
    q.push_back(64'h7100);
    tick();
    idle();
    tests++; if (bus.count_o !== 4'd8) begin fails++; $display("FAIL full_port1_count got %0d exp 8", bus.count_o); end
    tests++; if (bus.overflow_o !== 1'b0) begin fails++; $display("FAIL full_port1_overflow got %b exp 0", bus.overflow_o); end
    for (int j = 8; j < 16; j++) begin
      exp = mk(q[j], 1'b0, 3'd0, 5'd0, 64'd0, 2'd3);
      tests++; if (bus.fifo_entry_o !== exp) begin fails++; $display("FAIL full_drain_head[%0d] got %h exp %h", j, bus.fifo_entry_o, exp); end
      tick();
    end
    tests++; if (bus.fifo_entry_o !== '0) begin fails++; $display("FAIL full_drain_empty got %h exp 0", bus.fifo_entry_o); end
    tests++; if (bus.count_o !== 4'd0) begin fails++; $display("FAIL full_drain_count got %0d exp 0", bus.count_o); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      bus.valid_i = 2'b11;
      bus.pc_i[0] = 64'h8000 + 64'(16 * k);
      bus.pc_i[1] = 64'h8008 + 64'(16 * k);
      tick();
    end
    tests++; if (bus.count_o !== 4'd4) begin fails++; $display("FAIL rstmid_pre_count got %0d exp 4", bus.count_o); end
    #2;
    rst_ni = 1'b0;
    #1;
    tests++; if (bus.count_o !== 4'd0) begin fails++; $display("FAIL rstmid_count got %0d exp 0", bus.count_o); end
    tests++; if (bus.fifo_entry_o !== '0) begin fails++; $display("FAIL rstmid_entry got %h exp 0", bus.fifo_entry_o); end
    tests++; if (bus.overflow_o !== 1'b0) begin fails++; $display("FAIL rstmid_overflow got %b exp 0", bus.overflow_o); end
    idle();
    @(negedge clk);
    rst_ni = 1'b1;
    tick();
    tests++; if (bus.count_o !== 4'd0) begin fails++; $display("FAIL rstmid_after_count got %0d exp 0", bus.count_o); end
    tests++; if (bus.fifo_entry_o !== '0) begin fails++; $display("FAIL rstmid_after_entry got %h exp 0", bus.fifo_entry_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_dual();
    test_exception();
    test_overflow_wrap();
    test_flush();
    test_full_pop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
